// File: rtl/prog_run_ctrl.sv
// rtl/prog_run_ctrl.sv - run sequencer: parks/starts the core, times each run until Ack or timeout
// Optional feature macro: PROG_RUN_STATS_EN (adds StatRuns/StatTimeouts counters)
module prog_run_ctrl #(
  parameter int PW        = 2,
  parameter int CW        = 16,
  parameter int START_CYC = 2,
  parameter int MAX_CYC   = 4000
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic [PW-1:0] ReqProg,
  output logic          DutStart,
  output logic [PW-1:0] DutProgSel,
  input  logic          DutAck,
  output logic          RespValid,
  input  logic          RespReady,
  output logic [CW-1:0] RespCycles,
  output logic          RespTimeout,
  output logic [PW-1:0] RespProg
`ifdef PROG_RUN_STATS_EN
  ,
  output logic [15:0]   StatRuns,
  output logic [15:0]   StatTimeouts
`endif
);

  // Start counter only needs to hold START_CYC-1
  localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam logic [SW-1:0] START_LOAD = SW'(START_CYC - 1);
  localparam logic [CW-1:0] MAX_LAST   = CW'(MAX_CYC - 1);
  localparam logic [CW-1:0] MAX_VAL    = CW'(MAX_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [SW-1:0] startCnt;
  logic [CW-1:0] runCnt;
  // Keeps ReqReady low for the first clock after reset release
  logic          armed;

  assign ReqReady = (state == IDLE) && armed;

  // Sequencer FSM: accept, hold Start, time the run, present result
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      startCnt    <= '0;
      runCnt      <= '0;
      DutStart    <= 1'b1;
      DutProgSel  <= '0;
      RespValid   <= 1'b0;
      RespCycles  <= '0;
      RespTimeout <= 1'b0;
      RespProg    <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          DutStart <= 1'b1;
          if (ReqValid && ReqReady) begin
            DutProgSel <= ReqProg;
            RespProg   <= ReqProg;
            startCnt   <= START_LOAD;
            state      <= START;
          end
        end
        START: begin
          // Ack is deliberately ignored here: it is stale from the previous halt
          if (startCnt == '0) begin
            state    <= RUN;
            runCnt   <= '0;
            DutStart <= 1'b0;
          end else begin
            startCnt <= startCnt - 1'b1;
          end
        end
        RUN: begin
          // Ack takes priority over a timeout landing in the same cycle
          if (DutAck) begin
            state       <= DONE;
            RespCycles  <= runCnt;
            RespTimeout <= 1'b0;
            RespValid   <= 1'b1;
            DutStart    <= 1'b1;
          end else if (runCnt == MAX_LAST) begin
            state       <= DONE;
            RespCycles  <= MAX_VAL;
            RespTimeout <= 1'b1;
            RespValid   <= 1'b1;
            DutStart    <= 1'b1;
          end else begin
            runCnt <= runCnt + 1'b1;
          end
        end
        DONE: begin
          DutStart <= 1'b1;
          if (RespReady) begin
            RespValid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PROG_RUN_STATS_EN
  // Saturating run / timeout counters, bumped on each response handshake
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      StatRuns     <= '0;
      StatTimeouts <= '0;
    end else if ((state == DONE) && RespValid && RespReady) begin
      if (StatRuns != 16'hFFFF) StatRuns <= StatRuns + 16'd1;
      if (RespTimeout && (StatTimeouts != 16'hFFFF)) StatTimeouts <= StatTimeouts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_run_ctrl.sv
// tb/tb_prog_run_ctrl.sv - scoreboard bench for prog_run_ctrl with a processor Ack model
module tb_prog_run_ctrl;
  localparam int PW = 2;
  localparam int CW = 16;
  localparam int SC = 2;
  localparam int MC = 20;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          ReqValid;
  logic          ReqReady;
  logic [PW-1:0] ReqProg;
  logic          DutStart;
  logic [PW-1:0] DutProgSel;
  logic          DutAck;
  logic          RespValid;
  logic          RespReady;
  logic [CW-1:0] RespCycles;
  logic          RespTimeout;
  logic [PW-1:0] RespProg;
`ifdef PROG_RUN_STATS_EN
  logic [15:0]   StatRuns;
  logic [15:0]   StatTimeouts;
`endif

  prog_run_ctrl #(.PW(PW), .CW(CW), .START_CYC(SC), .MAX_CYC(MC)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqProg(ReqProg),
    .DutStart(DutStart), .DutProgSel(DutProgSel), .DutAck(DutAck),
    .RespValid(RespValid), .RespReady(RespReady), .RespCycles(RespCycles),
    .RespTimeout(RespTimeout), .RespProg(RespProg)
`ifdef PROG_RUN_STATS_EN
    , .StatRuns(StatRuns), .StatTimeouts(StatTimeouts)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [PW-1:0] prog;
    int            cycles;
    bit            tmo;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   ackAt = 1000;
  bit   staleAck = 1'b0;
  int   rrMode = 2;
  int   modelRuns = 0;
  int   modelTmos = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Processor model: Ack stays at the stale level while parked, rises ackAt cycles into a run
  initial begin
    int runIdx;
    runIdx = 0;
    DutAck = 1'b0;
    forever begin
      @(negedge Clk);
      if (DutStart !== 1'b0) begin
        runIdx = 0;
        DutAck = staleAck;
      end else begin
        DutAck = (runIdx >= ackAt);
        runIdx++;
      end
    end
  end

  // Host response acceptance: forced low, forced high, or random
  initial begin
    RespReady = 1'b0;
    forever begin
      @(posedge Clk);
      #1;
      case (rrMode)
        0:       RespReady = 1'b0;
        1:       RespReady = 1'b1;
        default: RespReady = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the expected result when a response appears, checks stability and return to idle
  initial begin
    bit            haveCur;
    bit            pendIdle;
    logic [PW-1:0] curProg;
    logic [CW-1:0] curCycles;
    logic          curTmo;
    exp_t          e;
    haveCur = 0;
    pendIdle = 0;
    curProg = '0;
    curCycles = '0;
    curTmo = 1'b0;
    forever begin
      @(negedge Clk);
      if (Reset !== 1'b1) begin
        haveCur = 0;
        pendIdle = 0;
      end else begin
        if (pendIdle) begin
          chk("hs_valid_cleared", RespValid, 0);
          chk("hs_back_to_idle", ReqReady, 1);
`ifdef PROG_RUN_STATS_EN
          chk("stat_runs", StatRuns, modelRuns);
          chk("stat_timeouts", StatTimeouts, modelTmos);
`endif
          pendIdle = 0;
          haveCur = 0;
        end
        if (RespValid === 1'b1) begin
          if (!haveCur) begin
            if (expQ.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL resp_unexpected: got response with empty scoreboard");
            end else begin
              e = expQ.pop_front();
              chk("resp_prog", RespProg, e.prog);
              chk("resp_cycles", RespCycles, e.cycles);
              chk("resp_timeout", RespTimeout, e.tmo);
            end
            curProg = RespProg;
            curCycles = RespCycles;
            curTmo = RespTimeout;
            haveCur = 1;
          end else begin
            chk("stable_prog", RespProg, curProg);
            chk("stable_cycles", RespCycles, curCycles);
            chk("stable_timeout", RespTimeout, curTmo);
          end
          if (RespReady === 1'b1) begin
            pendIdle = 1;
            modelRuns++;
            if (curTmo) modelTmos++;
          end
        end
      end
    end
  end

  task automatic noise();
    ReqValid = $urandom_range(0, 1);
    ReqProg = PW'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (ReqReady !== 1'b1 && t < 200) begin
      @(negedge Clk);
      t++;
    end
    chk(name, t < 200, 1);
  endtask

  // One run: ack delay k, stale Ack level while parked, hold RespReady low for hold DONE cycles
  task automatic run(input logic [PW-1:0] prog, input int k, input bit stale, input int hold);
    exp_t e;
    int n;
    int r;
    int d;
    e.prog = prog;
    e.cycles = (k < MC) ? k : MC;
    e.tmo = (k >= MC);
    expQ.push_back(e);
    ackAt = k;
    staleAck = stale;
    rrMode = (hold > 0) ? 0 : 2;
    wait_idle("req_ready_wait");
    ReqValid = 1'b1;
    ReqProg = prog;
    @(negedge Clk);
    chk("accept_ready_low", ReqReady, 0);
    n = 0;
    while (DutStart === 1'b1 && n < 50) begin
      chk("start_progsel", DutProgSel, prog);
      n++;
      noise();
      @(negedge Clk);
    end
    chk("start_width", n, SC);
    r = 0;
    while (DutStart === 1'b0 && r < 100) begin
      chk("run_progsel", DutProgSel, prog);
      r++;
      noise();
      @(negedge Clk);
    end
    chk("run_length", r, (k < MC) ? k + 1 : MC);
    d = 0;
    while (ReqReady !== 1'b1 && d < 200) begin
      chk("done_progsel", DutProgSel, prog);
      chk("done_dutstart", DutStart, 1);
      d++;
      if (hold > 0 && d == hold) rrMode = 1;
      noise();
      @(negedge Clk);
    end
    ReqValid = 1'b0;
    chk("done_exit", d < 200, 1);
    rrMode = 2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dutstart"}, DutStart, 1);
    chk({tag, "_reqready"}, ReqReady, 0);
    chk({tag, "_respvalid"}, RespValid, 0);
    chk({tag, "_respcycles"}, RespCycles, 0);
    chk({tag, "_resptimeout"}, RespTimeout, 0);
    chk({tag, "_respprog"}, RespProg, 0);
    chk({tag, "_progsel"}, DutProgSel, 0);
`ifdef PROG_RUN_STATS_EN
    chk({tag, "_statruns"}, StatRuns, 0);
    chk({tag, "_stattimeouts"}, StatTimeouts, 0);
`endif
  endtask

  // Reset in the middle of a run: outputs drop asynchronously and the pending result is discarded
  task automatic midrun_reset();
    exp_t e;
    int t;
    e.prog = 2'd3;
    e.cycles = MC;
    e.tmo = 1'b1;
    expQ.push_back(e);
    ackAt = 1000;
    staleAck = 1'b0;
    wait_idle("mr_ready_wait");
    ReqValid = 1'b1;
    ReqProg = 2'd3;
    @(negedge Clk);
    ReqValid = 1'b0;
    t = 0;
    while (DutStart !== 1'b0 && t < 50) begin
      @(negedge Clk);
      t++;
    end
    chk("mr_run_reached", t < 50, 1);
    repeat (7) @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk_reset_outputs("mr");
    void'(expQ.pop_back());
    modelRuns = 0;
    modelTmos = 0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    chk("mr_release_ready_low", ReqReady, 0);
    @(negedge Clk);
    chk("mr_release_ready_high", ReqReady, 1);
  endtask

  initial begin
    Reset = 1'b0;
    ReqValid = 1'b0;
    ReqProg = '0;
    repeat (3) @(negedge Clk);
    chk_reset_outputs("rst");
    Reset = 1'b1;
    chk("rst_release_ready_low", ReqReady, 0);
    @(negedge Clk);
    chk("rst_release_ready_high", ReqReady, 1);
    chk("rst_release_dutstart", DutStart, 1);
    chk("rst_release_respvalid", RespValid, 0);

    run(2'd1, 10, 1'b0, 0);
    run(2'd2, 100, 1'b0, 0);
    run(2'd3, 0, 1'b1, 0);
    run(2'd0, MC - 1, 1'b1, 0);
    run(2'd1, MC, 1'b0, 0);
    run(2'd2, 5, 1'b1, 5);
    run(2'd0, 1, 1'b0, 0);
    midrun_reset();
    run(2'd1, 3, 1'b1, 0);
    for (int i = 0; i < 25; i++) begin
      run(PW'($urandom), $urandom_range(0, MC + 5), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
    end
    repeat (4) @(negedge Clk);
    chk("scoreboard_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
